// File: rtl/hdr_frame_scheduler.sv
// hdr_frame_scheduler: HDR exposure sequencing, whole-frame admission and beat-count checking
module hdr_frame_scheduler #(
  parameter int BEATS_PER_FRAME = 460800,
  parameter int CNT_W = 20,
  parameter int TIMEOUT_CYC = 16777215
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        SOF,
  input  logic        EOF,
  input  logic        validY,
  output logic        cfg_req,
  input  logic        cfg_ack,
  output logic        exp_idx,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic        busy
);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] BEATS = CNT_W'(BEATS_PER_FRAME);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, CFG, WAIT_SOF, ACTIVE, CHECK} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [TMR_W-1:0] tmr;
  logic stop_pending, done_nxt, err_nxt, tmo, sof_beat, eof_beat;
  logic [1:0] code_nxt;
  assign tmo = tmr == TMR_LAST;
  assign sof_beat = validY & SOF;
  assign eof_beat = validY & EOF;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // An SOF seen in WAIT_SOF wins over a pending stop so an admitted frame is never cut short
  always_comb begin
    state_nxt = state;
    done_nxt = 1'b0;
    err_nxt = 1'b0;
    code_nxt = err_code;
    unique case (state)
      IDLE: state_nxt = start ? CFG : IDLE;
      CFG:
        if (cfg_ack) state_nxt = stop_pending ? IDLE : WAIT_SOF;
        else if (tmo) begin
          state_nxt = IDLE;
          err_nxt = 1'b1;
          code_nxt = 2'd2;
        end
      WAIT_SOF:
        if (sof_beat) state_nxt = ACTIVE;
        else if (stop_pending) state_nxt = IDLE;
        else if (tmo) begin
          state_nxt = IDLE;
          err_nxt = 1'b1;
          code_nxt = 2'd2;
        end
      ACTIVE:
        if (eof_beat) state_nxt = CHECK;
        else if (sof_beat) begin
          err_nxt = 1'b1;
          code_nxt = 2'd3;
        end
      CHECK: begin
        state_nxt = stop_pending ? IDLE : CFG;
        done_nxt = beat_cnt == BEATS;
        err_nxt = beat_cnt != BEATS;
        code_nxt = beat_cnt == BEATS ? 2'd0 : 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    out_valid = validY & ((state == WAIT_SOF & SOF) | state == ACTIVE);
    out_sof = SOF & out_valid;
    out_eof = EOF & out_valid;
    busy = state != IDLE;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      cfg_req <= 1'b0;
      exp_idx <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      err_code <= 2'd0;
      frame_cnt <= 16'd0;
      stop_pending <= 1'b0;
      tmr <= '0;
      beat_cnt <= '0;
    end else begin
      cfg_req <= state_nxt == CFG;
      frame_done <= done_nxt;
      frame_err <= err_nxt;
      if (done_nxt | err_nxt) err_code <= code_nxt;
      stop_pending <= state == IDLE ? 1'b0 : stop_pending | stop;
      tmr <= (state_nxt == state && (state == CFG || state == WAIT_SOF)) ? tmr + TMR_W'(1) : '0;
      if ((state == WAIT_SOF && sof_beat) || (state == ACTIVE && sof_beat && !EOF)) beat_cnt <= CNT_W'(1);
      else if (state == ACTIVE && validY && beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
      if (state == CHECK) begin
        frame_cnt <= frame_cnt + 16'd1;
        exp_idx <= ~exp_idx;
      end
    end
endmodule

// File: tb/tb_hdr_frame_scheduler.sv
// tb_hdr_frame_scheduler: directed stimulus with a queued scoreboard of done/err events
module tb_hdr_frame_scheduler;
  localparam int B = 48, CW = 6, T = 100;
  logic clk_sys = 0, reset_n = 0, start = 0, stop = 0, SOF = 0, EOF = 0, validY = 0, cfg_ack = 0;
  logic cfg_req, exp_idx, out_valid, out_sof, out_eof, frame_done, frame_err, busy;
  logic [1:0] err_code;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0, beats = 0;
  typedef struct packed {logic done; logic [1:0] code; logic [15:0] cnt; logic exp;} ev_t;
  ev_t q[$];

  hdr_frame_scheduler #(.BEATS_PER_FRAME(B), .CNT_W(CW), .TIMEOUT_CYC(T)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .stop(stop), .SOF(SOF), .EOF(EOF),
    .validY(validY), .cfg_req(cfg_req), .cfg_ack(cfg_ack), .exp_idx(exp_idx),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .frame_done(frame_done),
    .frame_err(frame_err), .err_code(err_code), .frame_cnt(frame_cnt), .busy(busy));

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_sys) if (reset_n) begin
    if (out_valid) beats++;
    if (frame_done | frame_err) begin
      chk("done/err exclusive", {31'd0, frame_done & frame_err}, 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected event: done=%0b err=%0b code=%0d", frame_done, frame_err, err_code);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("event is done", {31'd0, frame_done}, {31'd0, e.done});
        chk("event err_code", {30'd0, err_code}, {30'd0, e.code});
        chk("event frame_cnt", {16'd0, frame_cnt}, {16'd0, e.cnt});
        chk("event exp_idx", {31'd0, exp_idx}, {31'd0, e.exp});
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  // n junk beats while in CFG (must be blocked), then a one-cycle ack
  task automatic handshake(input int n);
    for (int i = 0; i < n; i++) begin
      validY = 1;
      SOF = (i % 2 == 0);
      EOF = (i % 3 == 0);
      step();
    end
    validY = 0; SOF = 0; EOF = 0;
    cfg_ack = 1;
    step();
    cfg_ack = 0;
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      validY = 1;
      SOF = 0;
      EOF = (i == 1);
      step();
    end
    validY = 0; EOF = 0;
  endtask

  // n beats, SOF on beat 0 (and sof2), EOF on the last beat, then one idle cycle for CHECK
  task automatic frame(input int n, input int sof2, input int stop_at, input bit last_sof);
    for (int i = 0; i < n; i++) begin
      validY = 1;
      SOF = (i == 0) || (i == sof2) || (last_sof && i == n - 1);
      EOF = (i == n - 1);
      stop = (i == stop_at);
      step();
    end
    validY = 0; SOF = 0; EOF = 0; stop = 0;
    step();
  endtask

  task automatic wait_timeout(input string name);
    int n = 0;
    while (!frame_err && n < 200) begin
      step();
      n++;
    end
    chk(name, n, T);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int b0;
    validY = 1; SOF = 1; EOF = 1;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset cfg_req", {31'd0, cfg_req}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset frame_cnt", {16'd0, frame_cnt}, 0);
    chk("reset exp_idx", {31'd0, exp_idx}, 0);
    chk("reset err_code", {30'd0, err_code}, 0);
    chk("reset out_valid", {31'd0, out_valid}, 0);
    validY = 0; SOF = 0; EOF = 0;
    reset_n = 1;
    step();
    cfg_ack = 1;
    step();
    cfg_ack = 0;
    chk("ack in idle ignored", {31'd0, busy}, 0);
    // first good frame, junk during CFG, SOF one cycle after ack
    b0 = beats;
    pulse_start();
    chk("cfg_req on start", {31'd0, cfg_req}, 1);
    chk("busy on start", {31'd0, busy}, 1);
    chk("first exp_idx", {31'd0, exp_idx}, 0);
    q.push_back(ev_t'{1'b1, 2'd0, 16'd1, 1'b1});
    handshake(5);
    chk("cfg_req drops after ack", {31'd0, cfg_req}, 0);
    frame(B, -1, -1, 0);
    chk("f1 beats passed", beats - b0, B);
    chk("f1 cfg_req again", {31'd0, cfg_req}, 1);
    chk("f1 exp_idx", {31'd0, exp_idx}, 1);
    chk("f1 frame_cnt", {16'd0, frame_cnt}, 1);
    // second frame with stop mid-frame and junk in WAIT_SOF
    b0 = beats;
    q.push_back(ev_t'{1'b1, 2'd0, 16'd2, 1'b0});
    handshake(2);
    junk(3);
    frame(B, -1, 20, 0);
    chk("f2 beats passed", beats - b0, B);
    chk("f2 idle after stop", {31'd0, busy}, 0);
    chk("f2 cfg_req", {31'd0, cfg_req}, 0);
    chk("f2 frame_cnt", {16'd0, frame_cnt}, 2);
    chk("f2 exp_idx", {31'd0, exp_idx}, 0);
    // short, long and saturating frames
    pulse_start();
    chk("restart exp_idx held", {31'd0, exp_idx}, 0);
    q.push_back(ev_t'{1'b0, 2'd1, 16'd3, 1'b1});
    handshake(1);
    frame(B - 1, -1, -1, 0);
    chk("short err_code held", {30'd0, err_code}, 1);
    b0 = beats;
    q.push_back(ev_t'{1'b0, 2'd1, 16'd4, 1'b0});
    handshake(1);
    frame(B + 1, -1, -1, 0);
    chk("long beats passed", beats - b0, B + 1);
    q.push_back(ev_t'{1'b0, 2'd1, 16'd5, 1'b1});
    handshake(1);
    frame(70, -1, -1, 0);
    // SOF inside ACTIVE restarts the count
    b0 = beats;
    q.push_back(ev_t'{1'b0, 2'd3, 16'd5, 1'b1});
    q.push_back(ev_t'{1'b1, 2'd0, 16'd6, 1'b0});
    handshake(1);
    frame(20 + B, 20, -1, 0);
    chk("resync beats passed", beats - b0, 20 + B);
    chk("resync err_code", {30'd0, err_code}, 0);
    // SOF and EOF together close the frame
    q.push_back(ev_t'{1'b1, 2'd0, 16'd7, 1'b1});
    handshake(1);
    frame(B, -1, -1, 1);
    stop = 1;
    step();
    stop = 0;
    handshake(0);
    chk("stop in CFG -> idle", {31'd0, busy}, 0);
    // timeouts in CFG and WAIT_SOF
    q.push_back(ev_t'{1'b0, 2'd2, 16'd7, 1'b1});
    pulse_start();
    wait_timeout("cfg timeout cycles");
    chk("cfg timeout cfg_req", {31'd0, cfg_req}, 0);
    chk("cfg timeout busy", {31'd0, busy}, 0);
    q.push_back(ev_t'{1'b0, 2'd2, 16'd7, 1'b1});
    pulse_start();
    handshake(2);
    wait_timeout("sof timeout cycles");
    chk("sof timeout busy", {31'd0, busy}, 0);
    // async reset in the middle of a frame
    pulse_start();
    handshake(0);
    validY = 1;
    SOF = 1;
    step();
    SOF = 0;
    repeat (9) step();
    chk("mid-frame pass", {31'd0, out_valid}, 1);
    #2 reset_n = 0;
    #1;
    chk("async rst out_valid", {31'd0, out_valid}, 0);
    chk("async rst busy", {31'd0, busy}, 0);
    chk("async rst exp_idx", {31'd0, exp_idx}, 0);
    chk("async rst frame_cnt", {16'd0, frame_cnt}, 0);
    chk("async rst err_code", {30'd0, err_code}, 0);
    chk("async rst cfg_req", {31'd0, cfg_req}, 0);
    validY = 0;
    chk("scoreboard drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
